sb_clk_gate_ctrl: RTL and testbench

//  Enable controller for the sideband clock-gating cell. Collects clock requests from N

---
 rtl/sb_clk_gate_ctrl.sv | 103 ++++++++++
 tb/tb_sb_clk_gate_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sb_clk_gate_ctrl.sv
// Enable controller for the sideband clock-gating cell: wake settle, steady on,
// idle hysteresis, and a per-requester REQ/ACK handshake while the clock runs.
module sb_clk_gate_ctrl #(
  parameter int N_REQ       = 3,
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             force_on_i,
  output logic [N_REQ-1:0] ack_o,
  output logic             clk_en_o,
  output logic [1:0]       gate_state_o
);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd3;

  localparam int MAX_CNT = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
  localparam int CNT_W   = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             any_req;

  // FORCE_ON keeps the clock running like a request but never earns an ACK.
  assign any_req = (|req_i) | force_on_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clk_en_d = clk_en_q;
    ack_d    = '0;
    case (state_q)
      S_OFF: begin
        clk_en_d = 1'b0;
        if (any_req) begin
          state_d  = S_WAKE;
          clk_en_d = 1'b1;
          cnt_d    = WAKE_LD;
        end
      end
      S_WAKE: begin
        clk_en_d = 1'b1;
        if (cnt_q == '0) state_d = S_ON;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_ON: begin
        clk_en_d = 1'b1;
        ack_d    = req_i;
        // Wait for every ACK to drain before starting hysteresis.
        if (!any_req && (ack_q == '0)) begin
          state_d = S_IDLE;
          cnt_d   = IDLE_LD;
        end
      end
      S_IDLE: begin
        clk_en_d = 1'b1;
        if (any_req) begin
          state_d = S_ON;
        end else if (cnt_q == '0) begin
          state_d  = S_OFF;
          clk_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d  = S_OFF;
        clk_en_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      ack_q    <= ack_d;
    end
  end

  assign ack_o        = ack_q;
  assign clk_en_o     = clk_en_q;
  assign gate_state_o = state_q;

endmodule

// File: tb/tb_sb_clk_gate_ctrl.sv
// Scoreboard bench for sb_clk_gate_ctrl: cycle model pushes expectations, DUT
// outputs are popped and compared after each edge, plus spec latency checks.
module tb_sb_clk_gate_ctrl;
  localparam int N_REQ = 3;
  localparam int WAKE  = 4;
  localparam int IDLE  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_REQ-1:0] req = '0;
  logic             force_on = 1'b0;
  logic [N_REQ-1:0] ack;
  logic             clk_en;
  logic [1:0]       gate_state;

  sb_clk_gate_ctrl #(
    .N_REQ      (N_REQ),
    .WAKE_CYCLES(WAKE),
    .IDLE_CYCLES(IDLE)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .force_on_i  (force_on),
    .ack_o       (ack),
    .clk_en_o    (clk_en),
    .gate_state_o(gate_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       st;
    logic             en;
    logic [N_REQ-1:0] ack;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   steps;
  int   at;

  logic [1:0]       m_st;
  logic             m_en;
  logic [N_REQ-1:0] m_ack;
  int               m_cnt;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st  = 2'd0;
    m_en  = 1'b0;
    m_ack = '0;
    m_cnt = 0;
  endtask

  // Next-state of the reference: what the outputs must be after the coming edge.
  task automatic model_step();
    logic any;
    logic [1:0] n_st;
    logic n_en;
    logic [N_REQ-1:0] n_ack;
    int n_cnt;
    any   = (req != '0) || force_on;
    n_st  = m_st;
    n_en  = m_en;
    n_ack = '0;
    n_cnt = m_cnt;
    if (m_st == 2'd0) begin
      if (any) begin n_st = 2'd1; n_en = 1'b1; n_cnt = WAKE; end
    end else if (m_st == 2'd1) begin
      if (m_cnt == 0) n_st = 2'd2;
      else            n_cnt = m_cnt - 1;
    end else if (m_st == 2'd2) begin
      n_ack = req;
      if (!any && m_ack == '0) begin n_st = 2'd3; n_cnt = IDLE; end
    end else begin
      if (any)              n_st = 2'd2;
      else if (m_cnt == 0)  begin n_st = 2'd0; n_en = 1'b0; end
      else                  n_cnt = m_cnt - 1;
    end
    m_st = n_st; m_en = n_en; m_ack = n_ack; m_cnt = n_cnt;
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e = '{st: m_st, en: m_en, ack: m_ack};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk_eq("sb_state", 32'(gate_state), 32'(e.st));
    chk_eq("sb_clk_en", 32'(clk_en), 32'(e.en));
    chk_eq("sb_ack", 32'(ack), 32'(e.ack));
  endtask

  function automatic bit met(input int cond);
    case (cond)
      0:       return clk_en == 1'b1;
      1:       return gate_state == 2'd2;
      2:       return ack != '0;
      3:       return ack == '0;
      4:       return gate_state == 2'd3;
      default: return clk_en == 1'b0;
    endcase
  endfunction

  // Steps until the condition holds; returns the step count, or -1 on timeout.
  task automatic run_until(input int cond, output int found);
    found = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      steps++;
      if (met(cond)) begin
        found = steps;
        break;
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    chk_eq("rst_state", 32'(gate_state), 0);
    chk_eq("rst_clk_en", 32'(clk_en), 0);
    chk_eq("rst_ack", 32'(ack), 0);
    rst = 1'b0;
    repeat (2) step();

    // Wake-up latency from a single request.
    req = 3'b001; steps = 0;
    run_until(0, at); chk_eq("wake_clk_en_at", at, 1);
    chk_eq("wake_state", 32'(gate_state), 1);
    run_until(1, at); chk_eq("wake_on_at", at, WAKE + 2);
    run_until(2, at); chk_eq("wake_ack_at", at, WAKE + 3);
    chk_eq("wake_ack_val", 32'(ack), 32'(3'b001));
    repeat (3) step();

    // Release and hysteresis.
    req = '0; steps = 0;
    run_until(3, at); chk_eq("rel_ack_low_at", at, 1);
    run_until(4, at); chk_eq("rel_idle_at", at, 2);
    run_until(5, at); chk_eq("rel_off_at", at, IDLE + 3);
    chk_eq("rel_off_state", 32'(gate_state), 0);

    // Request on the very edge the idle counter expires.
    req = 3'b001; steps = 0;
    run_until(2, at); chk_eq("re_ack_at", at, WAKE + 3);
    req = '0; steps = 0;
    run_until(4, at); chk_eq("re_idle_at", at, 2);
    repeat (IDLE) step();
    chk_eq("re_idle_hold", 32'(gate_state), 3);
    chk_eq("re_idle_en", 32'(clk_en), 1);
    req = 3'b100;
    step();
    chk_eq("race_state_on", 32'(gate_state), 2);
    chk_eq("race_en_kept", 32'(clk_en), 1);
    step();
    chk_eq("race_ack2", 32'(ack), 32'(3'b100));
    req = '0; steps = 0;
    run_until(5, at); chk_eq("race_off_at", at, IDLE + 3);

    // FORCE_ON: clock held on with no ACK; no ACK to drain on release.
    force_on = 1'b1; steps = 0;
    run_until(1, at); chk_eq("force_on_at", at, WAKE + 2);
    repeat (20) step();
    chk_eq("force_hold_state", 32'(gate_state), 2);
    chk_eq("force_no_ack", 32'(ack), 0);
    force_on = 1'b0; steps = 0;
    run_until(4, at); chk_eq("force_idle_at", at, 1);
    run_until(5, at); chk_eq("force_off_at", at, IDLE + 2);

    // Request pulse confined to WAKE: wake completes, no ACK, then gates off.
    req = 3'b010; steps = 0;
    step(); steps++;
    step(); steps++;
    req = '0;
    run_until(1, at); chk_eq("pulse_on_at", at, WAKE + 2);
    chk_eq("pulse_no_ack", 32'(ack), 0);
    run_until(4, at); chk_eq("pulse_idle_at", at, WAKE + 3);
    run_until(5, at); chk_eq("pulse_off_at", at, WAKE + IDLE + 4);

    // Asynchronous reset mid-ON, then re-wake with the request still held.
    req = 3'b001; steps = 0;
    run_until(2, at); chk_eq("pre_rst_ack_at", at, WAKE + 3);
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_state", 32'(gate_state), 0);
    chk_eq("arst_clk_en", 32'(clk_en), 0);
    chk_eq("arst_ack", 32'(ack), 0);
    model_reset();
    @(posedge clk);
    #1;
    chk_eq("arst_hold_en", 32'(clk_en), 0);
    rst = 1'b0; steps = 0;
    run_until(2, at); chk_eq("post_rst_ack_at", at, WAKE + 3);
    req = '0; steps = 0;
    run_until(5, at); chk_eq("post_rst_off_at", at, IDLE + 3);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
